// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with wrap-bit pointers, occupancy count,
// programmable almost-full/almost-empty, sticky overflow/underflow,
// synchronous flush and a registered read port with a valid strobe.
module sync_fifo_flags #(
    parameter int DATA_SIZE     = 8,
    parameter int ADDR_BITS     = 2,
    parameter int AFULL_THRESH  = 3,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [DATA_SIZE-1:0] wrdata,
    input  logic                 re,
    output logic [DATA_SIZE-1:0] rddata,
    output logic                 rvalid,
    input  logic                 flush,
    input  logic                 clr_err,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int PW    = ADDR_BITS + 1;

    // Thresholds fit in PW bits for legal parameter values (max = depth).
    localparam logic [PW-1:0] AF_T = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AE_T = PW'(AEMPTY_THRESH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wp, rp;
    logic                 wr_acc, rd_acc;

    // Flags derive only from registered pointers, so they move on edges only.
    assign count        = wp - rp;
    assign empty        = (wp == rp);
    assign full         = (wp[ADDR_BITS-1:0] == rp[ADDR_BITS-1:0]) &&
                          (wp[ADDR_BITS] != rp[ADDR_BITS]);
    assign almost_full  = (count >= AF_T);
    assign almost_empty = (count <= AE_T);

    // Acceptance uses pre-edge flags; flush suppresses both ports.
    assign wr_acc = we & ~full  & ~flush;
    assign rd_acc = re & ~empty & ~flush;

    // Pointer update: reset and flush both rewind to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_acc) wp <= wp + 1'b1;
            if (rd_acc) rp <= rp + 1'b1;
        end
    end

    // Storage write; contents are not reset.
    always_ff @(posedge clk) begin
        if (rst && wr_acc) mem[wp[ADDR_BITS-1:0]] <= wrdata;
    end

    // Registered read port; rddata holds its value when no read is accepted.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rddata <= '0;
            rvalid <= 1'b0;
        end else if (flush) begin
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) rddata <= mem[rp[ADDR_BITS-1:0]];
        end
    end

    // Sticky error flags: a new event in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (clr_err)              overflow  <= 1'b0;
            if (we & full & ~flush)   overflow  <= 1'b1;
            if (clr_err)              underflow <= 1'b0;
            if (re & empty & ~flush)  underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed checks of sync_fifo_flags (depth 4, AF=3, AE=1).
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst, we, re, flush, clr_err;
    logic [7:0] wrdata, rddata;
    logic       rvalid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    sync_fifo_flags #(.DATA_SIZE(8), .ADDR_BITS(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wrdata(wrdata), .re(re),
        .rddata(rddata), .rvalid(rvalid), .flush(flush), .clr_err(clr_err),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // count, empty, full, almost_empty, almost_full in one go
    task automatic chk_flags(input string tag, input int c, input bit e, input bit f,
                             input bit ae, input bit af);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"},  32'(full),  32'(f));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(ae));
        chk({tag, ".afull"},  32'(almost_full),  32'(af));
    endtask

    task automatic chk_rd(input string tag, input bit v, input logic [7:0] d);
        chk({tag, ".rvalid"}, 32'(rvalid), 32'(v));
        chk({tag, ".rddata"}, 32'(rddata), 32'(d));
    endtask

    task automatic chk_err(input string tag, input bit o, input bit u);
        chk({tag, ".overflow"},  32'(overflow),  32'(o));
        chk({tag, ".underflow"}, 32'(underflow), 32'(u));
    endtask

    logic [7:0] wrap_exp [10];

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; flush = 1'b0; clr_err = 1'b0; wrdata = 8'h00;
        tick();
        chk_flags("reset", 0, 1, 0, 1, 0);
        chk_rd("reset", 0, 8'h00);
        chk_err("reset", 0, 0);
        rst = 1'b1;

        // fill to full
        we = 1'b1;
        wrdata = 8'h11; tick(); chk_flags("wr1", 1, 0, 0, 1, 0);
        wrdata = 8'h22; tick(); chk_flags("wr2", 2, 0, 0, 0, 0);
        wrdata = 8'h33; tick(); chk_flags("wr3", 3, 0, 0, 0, 1);
        wrdata = 8'h44; tick(); chk_flags("wr4", 4, 0, 1, 0, 1);
        chk_err("wr4", 0, 0);

        // write while full
        wrdata = 8'h55; tick();
        chk_flags("ovf", 4, 0, 1, 0, 1);
        chk_err("ovf", 1, 0);
        we = 1'b0;

        // drain
        re = 1'b1;
        tick(); chk_rd("rd1", 1, 8'h11); chk("rd1.count", 32'(count), 3);
        tick(); chk_rd("rd2", 1, 8'h22);
        tick(); chk_rd("rd3", 1, 8'h33);
        tick(); chk_rd("rd4", 1, 8'h44); chk_flags("rd4", 0, 1, 0, 1, 0);

        // read while empty
        tick(); chk_rd("udf", 0, 8'h44); chk_err("udf", 1, 1);
        re = 1'b0;

        clr_err = 1'b1; tick(); chk_err("clr", 0, 0);

        // clr_err coinciding with a new underflow: set wins
        re = 1'b1; tick(); chk_err("clr_set", 0, 1); chk("clr_set.rvalid", 32'(rvalid), 0);
        re = 1'b0; tick(); chk_err("clr2", 0, 0);
        clr_err = 1'b0;

        // prime count 2 then 10 cycles of simultaneous write/read across the pointer wrap
        we = 1'b1;
        wrdata = 8'hA1; tick();
        wrdata = 8'hA2; tick(); chk_flags("prime", 2, 0, 0, 0, 0);
        wrap_exp[0] = 8'hA1; wrap_exp[1] = 8'hA2;
        for (int i = 2; i < 10; i++) wrap_exp[i] = 8'(i - 2);
        re = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wrdata = 8'(i);
            tick();
            chk_rd($sformatf("wrap%0d", i), 1, wrap_exp[i]);
            chk_flags($sformatf("wrap%0d", i), 2, 0, 0, 0, 0);
        end
        we = 1'b0;
        tick(); chk_rd("drain1", 1, 8'h08);
        tick(); chk_rd("drain2", 1, 8'h09); chk_flags("drain2", 0, 1, 0, 1, 0);
        chk_err("drain2", 0, 0);

        // we+re while empty: write wins, read rejected
        we = 1'b1; wrdata = 8'h66; tick();
        chk_flags("we_re_empty", 1, 0, 0, 1, 0);
        chk_rd("we_re_empty", 0, 8'h09);
        chk_err("we_re_empty", 0, 1);
        re = 1'b0;
        wrdata = 8'h77; tick();
        wrdata = 8'h88; tick();
        wrdata = 8'h99; tick(); chk_flags("refill", 4, 0, 1, 0, 1);

        // we+re while full: read wins, write rejected
        re = 1'b1; wrdata = 8'hBB; tick();
        chk_flags("we_re_full", 3, 0, 0, 0, 1);
        chk_rd("we_re_full", 1, 8'h66);
        chk_err("we_re_full", 1, 1);

        // flush with we and re, count 3
        flush = 1'b1; tick();
        chk_flags("flush", 0, 1, 0, 1, 0);
        chk_rd("flush", 0, 8'h66);
        chk_err("flush", 1, 1);
        flush = 1'b0; re = 1'b0;

        // reset mid-stream
        wrdata = 8'h12; tick();
        wrdata = 8'h34; re = 1'b1; tick();
        chk_rd("pre_rst", 1, 8'h12); chk("pre_rst.count", 32'(count), 1);
        rst = 1'b0; tick();
        chk_flags("mid_rst", 0, 1, 0, 1, 0);
        chk_rd("mid_rst", 0, 8'h00);
        chk_err("mid_rst", 0, 0);
        rst = 1'b1; we = 1'b0; re = 1'b0;
        tick(); chk_flags("post_rst", 0, 1, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO with extra-bit pointers, internal storage, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush and a registered read port with a valid strobe. It is the general-purpose single-clock buffer between producer and consumer logic in one clock domain. It supersedes fixed-flag FIFOs where back-pressure needs early warning or where misuse must be detected.

## Interface
Parameters:
- DATA_SIZE, 8, word width in bits (>= 1).
- ADDR_BITS, 2, address bits; depth = 2**ADDR_BITS (>= 1).
- AFULL_THRESH, 3, almost_full asserted when count >= this (1..depth).
- AEMPTY_THRESH, 1, almost_empty asserted when count <= this (0..depth-1).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-low.
- we  in  1  write request.
- wrdata  in  DATA_SIZE  write data.
- re  in  1  read request.
- rddata  out  DATA_SIZE  registered read data.
- rvalid  out  1  one-cycle strobe: rddata holds a newly read word.
- flush  in  1  synchronous clear of contents and pointers.
- clr_err  in  1  clears sticky overflow/underflow.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_THRESH.
- almost_empty  out  1  count <= AEMPTY_THRESH.
- count  out  ADDR_BITS+1  current occupancy, 0..depth.
- overflow  out  1  sticky: write requested while full.
- underflow  out  1  sticky: read requested while empty.

## Operation
- Pointers wp, rp are ADDR_BITS+1 wide; low ADDR_BITS index storage, MSB is the wrap bit. full = low bits equal and MSBs differ; empty = pointers equal. count = wp - rp modulo 2**(ADDR_BITS+1).
- Write accepted iff we & ~full: mem[wp low] <= wrdata, wp <= wp+1.
- Read accepted iff re & ~empty: rddata <= mem[rp low], rp <= rp+1, rvalid <= 1; otherwise rvalid <= 0 and rddata holds its value.
- Simultaneous accepted read and write: both proceed; count unchanged. Acceptance uses flags as they stand before the edge: write while full is rejected even if a read is accepted the same cycle; read while empty is rejected even if a write is accepted the same cycle.
- Pointer increment wraps naturally at 2**(ADDR_BITS+1); no special case.
- overflow <= 1 on we & full; underflow <= 1 on re & empty. Cleared only by clr_err or reset. If clr_err and a new error event coincide, the flag ends set (set wins).
- flush (rst high): wp <= 0, rp <= 0, rvalid <= 0; we/re ignored that cycle; rddata, error flags and storage unchanged.
- Priority: rst > flush > normal operation; clr_err is independent of flush.
- Storage is not reset; contents are undefined until written.

## Timing
- Reset (rst low at a rising edge): wp = rp = 0, rddata = 0, rvalid = 0, overflow = underflow = 0; hence empty = 1, full = 0, count = 0, almost_empty = 1, almost_full = (AFULL_THRESH == 0 ? 1 : 0) = 0 for legal parameters. Reset mid-operation discards all contents in that cycle.
- Read latency: re accepted at edge N -> rddata valid and rvalid = 1 after edge N, for one cycle unless another read is accepted at edge N+1 (back-to-back reads give rvalid high continuously, one word per cycle).
- Write-to-read: a word written at edge N is readable (empty = 0) after edge N; an accepted read at edge N+1 presents it after edge N+1.
- full, empty, count, almost_* are combinational from registered pointers: they change only after a clock edge, never from input changes within a cycle.
- Sustained throughput: one write and one read per cycle.

## Test plan
DATA_SIZE=8, ADDR_BITS=2 (depth 4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- Reset, then write 0x11,0x22,0x33,0x44 on 4 cycles -> count 1,2,3,4; almost_empty drops after count reaches 2; almost_full rises at count 3; full at 4; overflow stays 0.
- While full, assert we with 0x55 for 1 cycle -> count stays 4, overflow = 1; then read 4 words -> rddata 0x11,0x22,0x33,0x44 each one cycle after its read, rvalid high 4 cycles, empty = 1 at end; 0x55 never appears.
- While empty, assert re -> rvalid stays 0, underflow = 1; pulse clr_err -> overflow = underflow = 0 next cycle.
- Wrap: 10 cycles of simultaneous we/re starting at count 2 with data 0x00..0x09 -> count stays 2, read data is the prior contents followed by 0x00..0x07 in order, pointers wrap past 7 with no glitch on full/empty.
- Simultaneous we and re while empty -> write accepted, read rejected, count = 1, rvalid = 0, underflow = 1; similarly we and re while full -> read accepted (rvalid = 1), write rejected, count = 3, overflow = 1.
- With count 3, assert flush together with we and re -> next cycle count = 0, empty = 1, rvalid = 0, error flags unchanged; pull rst low mid-stream -> all outputs at reset values after that edge.
